// File: rtl/spi_frame_pkg.sv
// Shared constants and state types for the SPI frame buffer.
// The frame store is addressed as {bank, byte index}.
package spi_frame_pkg;

    localparam int FRAME_BYTES = 16;
    localparam int DATA_W      = 8;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam int ADDR_W      = IDX_W + 1;
    localparam int SEQ_W       = 8;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
    localparam logic [SEQ_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        FILL,
        HOLD
    } wr_state_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } rd_state_t;

    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank,
                                                     input logic [IDX_W-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank byte store: one write port and one registered read port.
// The read register only updates when re is high, so it holds its last byte otherwise.
module frame_bank_ram
    import spi_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2*FRAME_BYTES];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_frame_buffer.sv
// Double-buffered frame store feeding the SPI slave: the producer fills the free bank,
// and the reader swaps to the newest complete frame only on rd_start.
//
//  state  | meaning
//  FILL   | writer accepting bytes into the free bank
//  HOLD   | complete frame pending, writer back-pressured until a swap
//  IDLE   | no SPI frame in progress, rd_data holds
//  ACTIVE | SPI frame in progress, rd_data tracks the read index
module spi_frame_buffer
    import spi_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_start,
    input  logic              rd_next,
    input  logic              rd_stop,
    output logic [DATA_W-1:0] rd_data,
    output logic [SEQ_W-1:0]  rd_seq,
    output logic              rd_stale,
    output logic [SEQ_W-1:0]  drop_cnt
);

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              pending_q, pending_d;
    logic              bank_sel_q, bank_sel_d;
    logic              committed_q, committed_d;
    logic [SEQ_W-1:0]  wr_seq_q, wr_seq_d;
    logic [SEQ_W-1:0]  rd_seq_q, rd_seq_d;
    logic              rd_stale_q, rd_stale_d;
    logic [SEQ_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              wr_accept;
    logic              wr_last;
    logic              swap;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;

    always_comb begin
        wr_accept = (wr_state_q == FILL) && wr_valid;
        wr_last   = wr_accept && (wr_idx_q == IDX_LAST);
        // Only a commit registered before this edge can be swapped in.
        swap      = rd_start && pending_q;
    end

    // Write side
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_idx_d    = wr_idx_q;
        wr_seq_d    = wr_seq_q;
        pending_d   = pending_q;
        committed_d = committed_q;
        wr_ready    = 1'b0;

        case (wr_state_q)
            FILL: begin
                wr_ready = 1'b1;
                if (wr_accept) begin
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                end
                if (wr_last) begin
                    wr_idx_d    = '0;
                    pending_d   = 1'b1;
                    committed_d = 1'b1;
                    wr_seq_d    = wr_seq_q + SEQ_W'(1);
                    wr_state_d  = HOLD;
                end
            end
            HOLD: begin
                if (swap) begin
                    pending_d  = 1'b0;
                    wr_state_d = FILL;
                end
            end
            default: begin
                wr_state_d = FILL;
            end
        endcase
    end

    // Read side
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        bank_sel_d = bank_sel_q;
        rd_seq_d   = rd_seq_q;
        rd_stale_d = rd_stale_q;
        drop_cnt_d = drop_cnt_q;

        if (rd_start) begin
            rd_idx_d   = '0;
            rd_state_d = ACTIVE;
            if (swap) begin
                bank_sel_d = ~bank_sel_q;
                rd_seq_d   = wr_seq_q;
                rd_stale_d = 1'b0;
            end else begin
                rd_stale_d = 1'b1;
                if (!committed_q && (drop_cnt_q != CNT_MAX)) begin
                    drop_cnt_d = drop_cnt_q + SEQ_W'(1);
                end
            end
        end else if (rd_stop) begin
            rd_state_d = IDLE;
        end else if (rd_next && (rd_state_q == ACTIVE)) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q  <= FILL;
            rd_state_q  <= IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            pending_q   <= 1'b0;
            bank_sel_q  <= 1'b0;
            committed_q <= 1'b0;
            wr_seq_q    <= '0;
            rd_seq_q    <= '0;
            rd_stale_q  <= 1'b1;
            drop_cnt_q  <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            pending_q   <= pending_d;
            bank_sel_q  <= bank_sel_d;
            committed_q <= committed_d;
            wr_seq_q    <= wr_seq_d;
            rd_seq_q    <= rd_seq_d;
            rd_stale_q  <= rd_stale_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Writer always targets the bank the reader is not using.
    always_comb begin
        ram_we    = wr_accept && rst_n;
        ram_waddr = bank_addr(~bank_sel_q, wr_idx_q);
        ram_re    = (rd_state_q == ACTIVE);
        ram_raddr = bank_addr(bank_sel_q, rd_idx_q);
    end

    frame_bank_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

    assign rd_seq   = rd_seq_q;
    assign rd_stale = rd_stale_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Self-checking bench for spi_frame_buffer: a frame-level model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_spi_frame_buffer;

    localparam int FB = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       rd_start;
    logic       rd_next;
    logic       rd_stop;
    logic [7:0] rd_data;
    logic [7:0] rd_seq;
    logic       rd_stale;
    logic [7:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    spi_frame_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_start (rd_start),
        .rd_next  (rd_next),
        .rd_stop  (rd_stop),
        .rd_data  (rd_data),
        .rd_seq   (rd_seq),
        .rd_stale (rd_stale),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: staging frame, one waiting frame, the frame being served.
    int m_stage[FB];
    int m_pend[FB];
    int m_srv[FB];
    int m_wcnt, m_wr_seq, m_rd_seq, m_drop, m_idx, m_rd_data;
    bit m_pending, m_committed, m_stale, m_active, m_srv_known, m_rd_known;
    bit p0, c0;
    int s0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_wcnt = 0; m_wr_seq = 0; m_rd_seq = 0; m_drop = 0; m_idx = 0;
            m_rd_data = 0; m_rd_known = 1;
            m_pending = 0; m_committed = 0; m_stale = 1; m_active = 0; m_srv_known = 0;
        end else begin
            p0 = m_pending; c0 = m_committed; s0 = m_wr_seq;
            if (m_active) begin
                if (m_srv_known) begin
                    m_rd_data  = m_srv[m_idx];
                    m_rd_known = 1;
                end else begin
                    m_rd_known = 0;
                end
            end
            if (wr_valid && !p0) begin
                m_stage[m_wcnt] = int'(wr_data);
                m_wcnt++;
                if (m_wcnt == FB) begin
                    m_pend      = m_stage;
                    m_pending   = 1;
                    m_committed = 1;
                    m_wr_seq    = (m_wr_seq + 1) % 256;
                    m_wcnt      = 0;
                end
            end
            if (rd_start) begin
                m_idx    = 0;
                m_active = 1;
                if (p0) begin
                    m_srv       = m_pend;
                    m_srv_known = 1;
                    m_rd_seq    = s0;
                    m_pending   = 0;
                    m_stale     = 0;
                end else begin
                    m_stale = 1;
                    if (!c0 && m_drop < 255) m_drop++;
                end
            end else if (rd_stop) begin
                m_active = 0;
            end else if (rd_next && m_active) begin
                m_idx = (m_idx + 1) % FB;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model wr_ready", int'(wr_ready), int'(!m_pending));
            chk("model rd_seq", int'(rd_seq), m_rd_seq);
            chk("model rd_stale", int'(rd_stale), int'(m_stale));
            chk("model drop_cnt", int'(drop_cnt), m_drop);
            if (m_rd_known) chk("model rd_data", int'(rd_data), m_rd_data);
        end
    end

    task automatic step(input bit v, input int d, input bit st, input bit nx, input bit sp);
        @(negedge clk);
        wr_valid = v;
        wr_data  = 8'(d);
        rd_start = st;
        rd_next  = nx;
        rd_stop  = sp;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < FB; i++) step(1, base + i, 0, 0, 0);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; wr_valid = 0; wr_data = 0; rd_start = 0; rd_next = 0; rd_stop = 0;
        settle();
        chk("reset wr_ready", int'(wr_ready), 1);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset rd_seq", int'(rd_seq), 0);
        chk("reset rd_stale", int'(rd_stale), 1);
        chk("reset drop_cnt", int'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; wr_valid = 0; wr_data = 0; rd_start = 0; rd_next = 0; rd_stop = 0;
        settle();
        chk_en = 1;
        do_reset();

        // rd_start with nothing ever committed, then drop counter saturation
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("drop first stale", int'(rd_stale), 1);
        chk("drop first cnt", int'(drop_cnt), 1);
        repeat (299) step(0, 0, 1, 0, 0);
        idle(); settle();
        chk("drop saturate", int'(drop_cnt), 255);

        // one frame 0x01..0x10 read out in order
        do_reset();
        push_frame(8'h01);
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < FB; k++) begin
            if (k > 0) step(0, 0, 0, 1, 0);
            idle(); settle();
            chk("frame1 byte", int'(rd_data), k + 1);
        end
        chk("frame1 rd_seq", int'(rd_seq), 1);
        chk("frame1 stale", int'(rd_stale), 0);

        // 16th rd_next wraps to byte 0; IDLE ignores rd_next and holds data
        step(0, 0, 0, 1, 0); idle(); settle();
        chk("wrap byte0", int'(rd_data), 8'h01);
        step(0, 0, 0, 0, 1); step(0, 0, 0, 1, 0); idle(); settle();
        chk("idle hold", int'(rd_data), 8'h01);
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("restart stale", int'(rd_stale), 1);
        chk("restart seq", int'(rd_seq), 1);
        chk("restart no drop", int'(drop_cnt), 0);

        // backpressure while a frame waits, then two swaps
        do_reset();
        push_frame(8'h40); settle();
        chk("bp after A", int'(wr_ready), 0);
        push_frame(8'h60); settle();
        chk("bp refused", int'(wr_ready), 0);
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("A ready", int'(wr_ready), 1);
        chk("A byte0", int'(rd_data), 8'h40);
        chk("A seq", int'(rd_seq), 1);
        push_frame(8'h80); settle();
        chk("bp after B", int'(wr_ready), 0);
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("B seq", int'(rd_seq), 2);
        chk("B byte0", int'(rd_data), 8'h80);
        chk("B stale", int'(rd_stale), 0);
        step(0, 0, 0, 1, 0); idle(); settle();
        chk("B byte1", int'(rd_data), 8'h81);

        // commit on the same cycle as rd_start is not visible to it
        for (int i = 0; i < FB - 1; i++) step(1, 8'hC0 + i, 0, 0, 0);
        step(1, 8'hCF, 1, 0, 0); idle(); settle();
        chk("same-cycle stale", int'(rd_stale), 1);
        chk("same-cycle seq", int'(rd_seq), 2);
        chk("same-cycle old data", int'(rd_data), 8'h80);
        chk("same-cycle bp", int'(wr_ready), 0);
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("C stale", int'(rd_stale), 0);
        chk("C seq", int'(rd_seq), 3);
        chk("C byte0", int'(rd_data), 8'hC0);

        // reset with a pending frame, then with a partial frame
        push_frame(8'hD0);
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 8'hA0 + i, 0, 0, 0);
        do_reset();
        push_frame(8'hE0);
        step(0, 0, 1, 0, 0); idle(); settle();
        chk("post-reset seq", int'(rd_seq), 1);
        chk("post-reset byte0", int'(rd_data), 8'hE0);
        chk("post-reset stale", int'(rd_stale), 0);
        chk("post-reset drop", int'(drop_cnt), 0);
        step(0, 0, 0, 1, 0); idle(); settle();
        chk("post-reset byte1", int'(rd_data), 8'hE1);

        repeat (3) idle();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
